// File: rtl/fu_result_buffer.sv
// fu_result_buffer
// Holds up to DEPTH completed functional-unit results (value, ROB tag and
// exception/redirect flags) until a result bus lane is granted. Up to
// NUM_PORTS entries are broadcast per cycle in round-robin order. Entries
// whose tag is at or younger than flush_start_tag are squashed on flush.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   value_in, tag_in, *_in      result presented by the FU
//   write_en / write_ready      FU write handshake (ready = !full)
//   flush, flush_start_tag      wrap-aware tag squash
//   bus_permit                  per-lane grant from the bus arbiter
//   bus_*                       lane payloads, Z when the lane is not granted
//   bus_valid                   lane carries a real entry
//   not_empty, full, count      occupancy status
//   overflow                    sticky: write attempted while not ready
//   valid                       per-entry valid bits (debug)
module fu_result_buffer #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int DEPTH         = 4,
  parameter int NUM_PORTS     = 1,
  parameter int IDX_W         = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [XLEN-1:0]                  value_in,
  input  logic [ROB_TAG_WIDTH-1:0]         tag_in,
  input  logic                             uarch_exception_in,
  input  logic                             arch_exception_in,
  input  logic                             redirect_mispredicted_in,
  input  logic                             write_en,
  output logic                             write_ready,
  input  logic                             flush,
  input  logic [ROB_TAG_WIDTH-1:0]         flush_start_tag,
  input  logic [NUM_PORTS-1:0]             bus_permit,
  output logic [NUM_PORTS*XLEN-1:0]        bus_data,
  output logic [NUM_PORTS*ROB_TAG_WIDTH-1:0] bus_tag,
  output logic [NUM_PORTS-1:0]             bus_uarch_exception,
  output logic [NUM_PORTS-1:0]             bus_arch_exception,
  output logic [NUM_PORTS-1:0]             bus_redirect_mispredicted,
  output logic [NUM_PORTS-1:0]             bus_valid,
  output logic                             not_empty,
  output logic                             full,
  output logic [IDX_W:0]                   count,
  output logic                             overflow,
  output logic [DEPTH-1:0]                 valid
);

  logic [XLEN-1:0]          value_q [DEPTH];
  logic [ROB_TAG_WIDTH-1:0] tag_q   [DEPTH];
  logic [DEPTH-1:0]         uexc_q;
  logic [DEPTH-1:0]         aexc_q;
  logic [DEPTH-1:0]         redir_q;
  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         valid_nxt;
  logic [DEPTH-1:0]         squash_vec;
  logic [IDX_W-1:0]         last_idx;
  logic [IDX_W:0]           count_q;
  logic [IDX_W:0]           count_nxt;
  logic                     overflow_q;

  logic [IDX_W-1:0]         cand_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]     cand_ok;
  logic [NUM_PORTS-1:0]     lane_fire;
  logic [IDX_W-1:0]         free_idx;
  logic                     write_squashed;
  logic                     do_write;

  // Wrap-aware age test: tag is at or younger than the flush point when the
  // modular difference is non-negative.
  function automatic logic is_squashed(input logic [ROB_TAG_WIDTH-1:0] t,
                                       input logic [ROB_TAG_WIDTH-1:0] f);
    logic [ROB_TAG_WIDTH-1:0] d;
    d = t - f;
    return !d[ROB_TAG_WIDTH-1];
  endfunction

  assign full        = &valid_q;
  assign not_empty   = |valid_q;
  assign write_ready = !full;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign valid       = valid_q;

  // Circular scan starting just past the last broadcast slot; the (p+1)-th
  // valid entry found becomes the candidate for lane p.
  always_comb begin
    logic [IDX_W:0]   found;
    logic [IDX_W-1:0] idx;
    found   = '0;
    idx     = '0;
    cand_ok = '0;
    for (int p = 0; p < NUM_PORTS; p++) cand_idx[p] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = last_idx + IDX_W'(k + 1);
      if (valid_q[idx]) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (found == (IDX_W+1)'(p)) begin
            cand_idx[p] = idx;
            cand_ok[p]  = 1'b1;
          end
        end
        found = found + 1'b1;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    squash_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_vec[i] = flush && is_squashed(tag_q[i], flush_start_tag);
    end
  end

  assign write_squashed = flush && is_squashed(tag_in, flush_start_tag);
  assign do_write       = write_en && write_ready && !write_squashed;

  // The write slot was free at the start of the cycle, so setting it last
  // can never undo a broadcast or flush clear.
  always_comb begin
    valid_nxt = valid_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (lane_fire[p]) valid_nxt[cand_idx[p]] = 1'b0;
    end
    valid_nxt = valid_nxt & ~squash_vec;
    if (do_write) valid_nxt[free_idx] = 1'b1;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + (IDX_W+1)'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_idx   <= IDX_W'(DEPTH - 1);
    end else begin
      valid_q <= valid_nxt;
      count_q <= count_nxt;
      if (write_en && !write_ready) overflow_q <= 1'b1;
      // Highest-numbered broadcasting lane wins.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (lane_fire[p]) last_idx <= cand_idx[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      value_q[free_idx] <= value_in;
      tag_q[free_idx]   <= tag_in;
      uexc_q[free_idx]  <= uarch_exception_in;
      aexc_q[free_idx]  <= arch_exception_in;
      redir_q[free_idx] <= redirect_mispredicted_in;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    assign lane_fire[p] = bus_permit[p] && cand_ok[p];
    assign bus_valid[p] = lane_fire[p];
    assign bus_data[p*XLEN +: XLEN] = !bus_permit[p] ? {XLEN{1'bz}} :
                                      (cand_ok[p] ? value_q[cand_idx[p]] : '0);
    assign bus_tag[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH] =
      !bus_permit[p] ? {ROB_TAG_WIDTH{1'bz}} :
      (cand_ok[p] ? tag_q[cand_idx[p]] : '0);
    assign bus_uarch_exception[p] = !bus_permit[p] ? 1'bz :
                                    (cand_ok[p] && uexc_q[cand_idx[p]]);
    assign bus_arch_exception[p] = !bus_permit[p] ? 1'bz :
                                   (cand_ok[p] && aexc_q[cand_idx[p]]);
    assign bus_redirect_mispredicted[p] = !bus_permit[p] ? 1'bz :
                                          (cand_ok[p] && redir_q[cand_idx[p]]);
  end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: instance A (DEPTH=4, one lane) runs a
// cycle-by-cycle vector table; instance B (DEPTH=8, two lanes) uses a
// tag scoreboard for the multi-lane and non-contiguous permit sequences.
module tb_fu_result_buffer;
  localparam int XLEN = 32;
  localparam int TW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // instance A
  logic [XLEN-1:0] a_value;
  logic [TW-1:0]   a_tag, a_ftag;
  logic            a_uexc, a_aexc, a_redir, a_we, a_flush;
  logic [0:0]      a_permit;
  wire  [XLEN-1:0] a_bus_data;
  wire  [TW-1:0]   a_bus_tag;
  wire  [0:0]      a_bus_uexc, a_bus_aexc, a_bus_redir, a_bus_valid;
  wire             a_ready, a_not_empty, a_full, a_overflow;
  wire  [2:0]      a_count;
  wire  [3:0]      a_valid;

  // instance B
  logic [XLEN-1:0]   b_value;
  logic [TW-1:0]     b_tag, b_ftag;
  logic              b_uexc, b_aexc, b_redir, b_we, b_flush;
  logic [1:0]        b_permit;
  wire  [2*XLEN-1:0] b_bus_data;
  wire  [2*TW-1:0]   b_bus_tag;
  wire  [1:0]        b_bus_uexc, b_bus_aexc, b_bus_redir, b_bus_valid;
  wire               b_ready, b_not_empty, b_full, b_overflow;
  wire  [3:0]        b_count;
  wire  [7:0]        b_valid;

  fu_result_buffer #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .DEPTH(4), .NUM_PORTS(1)) u_a (
    .clk(clk), .reset(reset), .value_in(a_value), .tag_in(a_tag),
    .uarch_exception_in(a_uexc), .arch_exception_in(a_aexc),
    .redirect_mispredicted_in(a_redir), .write_en(a_we), .write_ready(a_ready),
    .flush(a_flush), .flush_start_tag(a_ftag), .bus_permit(a_permit),
    .bus_data(a_bus_data), .bus_tag(a_bus_tag), .bus_uarch_exception(a_bus_uexc),
    .bus_arch_exception(a_bus_aexc), .bus_redirect_mispredicted(a_bus_redir),
    .bus_valid(a_bus_valid), .not_empty(a_not_empty), .full(a_full),
    .count(a_count), .overflow(a_overflow), .valid(a_valid));

  fu_result_buffer #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .DEPTH(8), .NUM_PORTS(2)) u_b (
    .clk(clk), .reset(reset), .value_in(b_value), .tag_in(b_tag),
    .uarch_exception_in(b_uexc), .arch_exception_in(b_aexc),
    .redirect_mispredicted_in(b_redir), .write_en(b_we), .write_ready(b_ready),
    .flush(b_flush), .flush_start_tag(b_ftag), .bus_permit(b_permit),
    .bus_data(b_bus_data), .bus_tag(b_bus_tag), .bus_uarch_exception(b_bus_uexc),
    .bus_arch_exception(b_bus_aexc), .bus_redirect_mispredicted(b_bus_redir),
    .bus_valid(b_bus_valid), .not_empty(b_not_empty), .full(b_full),
    .count(b_count), .overflow(b_overflow), .valid(b_valid));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Payload and flags are derived from the tag so every lane check covers them.
  function automatic logic [XLEN-1:0] vdat(input logic [TW-1:0] t);
    return 32'hC0DE_0000 | 32'(t) * 32'h101;
  endfunction

  typedef struct {
    logic          we;
    logic [TW-1:0] tag;
    logic          permit;
    logic          flush;
    logic [TW-1:0] ftag;
    logic          e_ready;
    logic          e_full;
    logic          e_bvalid;
    logic [TW-1:0] e_btag;
    logic [2:0]    e_count;
    logic          e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic we, input int tag, input logic pm,
                              input logic fl, input int ft, input logic er,
                              input logic ef, input logic ebv, input int ebt,
                              input int ec, input logic eo);
    vec_t v;
    v.we = we; v.tag = TW'(tag); v.permit = pm; v.flush = fl; v.ftag = TW'(ft);
    v.e_ready = er; v.e_full = ef; v.e_bvalid = ebv; v.e_btag = TW'(ebt);
    v.e_count = 3'(ec); v.e_ovf = eo;
    return v;
  endfunction

  task automatic a_drive(input logic we, input logic [TW-1:0] tag, input logic pm,
                         input logic fl, input logic [TW-1:0] ft);
    a_we = we; a_tag = tag; a_value = vdat(tag);
    a_uexc = tag[0]; a_aexc = tag[1]; a_redir = tag[2];
    a_permit = pm; a_flush = fl; a_ftag = ft;
  endtask

  task automatic b_drive(input logic we, input logic [TW-1:0] tag, input logic [1:0] pm,
                         input logic fl, input logic [TW-1:0] ft);
    b_we = we; b_tag = tag; b_value = vdat(tag);
    b_uexc = tag[0]; b_aexc = tag[1]; b_redir = tag[2];
    b_permit = pm; b_flush = fl; b_ftag = ft;
  endtask

  localparam int NV = 25;
  vec_t tbl[NV];
  logic [TW-1:0] sb[$];

  initial begin
    logic [2:0] prev_count;
    logic [TW-1:0] exp_t;
    logic [TW-1:0] lt;
    logic [1:0] exp_bv3 [3];
    logic [3:0] exp_cnt3 [3];

    //            we tag pm fl ft   rdy full bv btag cnt ovf
    tbl[0]  = mk(1,  3, 0, 0,  0,   1,  0,   0,  0,  1,  0);
    tbl[1]  = mk(1,  4, 0, 0,  0,   1,  0,   0,  0,  2,  0);
    tbl[2]  = mk(1,  5, 0, 0,  0,   1,  0,   0,  0,  3,  0);
    tbl[3]  = mk(0,  0, 1, 0,  0,   1,  0,   1,  3,  2,  0);
    tbl[4]  = mk(0,  0, 1, 0,  0,   1,  0,   1,  4,  1,  0);
    tbl[5]  = mk(0,  0, 1, 0,  0,   1,  0,   1,  5,  0,  0);
    tbl[6]  = mk(1,  6, 0, 0,  0,   1,  0,   0,  0,  1,  0);
    tbl[7]  = mk(1,  7, 0, 0,  0,   1,  0,   0,  0,  2,  0);
    tbl[8]  = mk(1,  8, 0, 0,  0,   1,  0,   0,  0,  3,  0);
    tbl[9]  = mk(1,  9, 0, 0,  0,   1,  0,   0,  0,  4,  0);
    tbl[10] = mk(1, 10, 1, 0,  0,   0,  1,   1,  9,  3,  1);
    tbl[11] = mk(0,  0, 1, 0,  0,   1,  0,   1,  6,  2,  1);
    tbl[12] = mk(0,  0, 1, 0,  0,   1,  0,   1,  7,  1,  1);
    tbl[13] = mk(0,  0, 1, 0,  0,   1,  0,   1,  8,  0,  1);
    tbl[14] = mk(0,  0, 1, 0,  0,   1,  0,   0,  0,  0,  1);
    tbl[15] = mk(1, 30, 0, 0,  0,   1,  0,   0,  0,  1,  1);
    tbl[16] = mk(1, 31, 0, 0,  0,   1,  0,   0,  0,  2,  1);
    tbl[17] = mk(1,  0, 0, 0,  0,   1,  0,   0,  0,  3,  1);
    tbl[18] = mk(1,  1, 0, 0,  0,   1,  0,   0,  0,  4,  1);
    tbl[19] = mk(1,  2, 0, 1, 31,   0,  1,   0,  0,  1,  1);
    tbl[20] = mk(0,  0, 1, 0,  0,   1,  0,   1, 30,  0,  1);
    tbl[21] = mk(1,  2, 0, 0,  0,   1,  0,   0,  0,  1,  1);
    tbl[22] = mk(1,  6, 0, 0,  0,   1,  0,   0,  0,  2,  1);
    tbl[23] = mk(0,  0, 1, 1,  4,   1,  0,   1,  6,  1,  1);
    tbl[24] = mk(0,  0, 1, 0,  0,   1,  0,   1,  2,  0,  1);

    reset = 1'b0;
    a_drive(0, 0, 0, 0, 0);
    b_drive(0, 0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    a_permit = 1'b1;
    @(negedge clk);
    chk("reset_count", 32'(a_count), 0);
    chk("reset_valid", 32'(a_valid), 0);
    chk("reset_ready", 32'(a_ready), 1);
    chk("reset_not_empty", 32'(a_not_empty), 0);
    chk("reset_full", 32'(a_full), 0);
    chk("reset_overflow", 32'(a_overflow), 0);
    chk("reset_bus_valid", 32'(a_bus_valid), 0);
    @(posedge clk);
    #1;

    prev_count = 3'd0;
    for (int i = 0; i < NV; i++) begin
      a_drive(tbl[i].we, tbl[i].tag, tbl[i].permit, tbl[i].flush, tbl[i].ftag);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(a_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_full", i), 32'(a_full), 32'(tbl[i].e_full));
      chk($sformatf("v%0d_not_empty", i), 32'(a_not_empty), 32'(prev_count != 0));
      chk($sformatf("v%0d_bus_valid", i), 32'(a_bus_valid), 32'(tbl[i].e_bvalid));
      if (tbl[i].permit) begin
        exp_t = tbl[i].e_bvalid ? tbl[i].e_btag : '0;
        chk($sformatf("v%0d_bus_tag", i), 32'(a_bus_tag), 32'(exp_t));
        chk($sformatf("v%0d_bus_data", i), a_bus_data, tbl[i].e_bvalid ? vdat(exp_t) : 32'h0);
        chk($sformatf("v%0d_bus_flags", i), {29'b0, a_bus_redir, a_bus_aexc, a_bus_uexc},
            32'(exp_t[2:0]));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 32'(a_count), 32'(tbl[i].e_count));
      chk($sformatf("v%0d_overflow", i), 32'(a_overflow), 32'(tbl[i].e_ovf));
      prev_count = tbl[i].e_count;
    end
    a_drive(0, 0, 0, 0, 0);

    // mid-operation reset with three valid entries and a write pending
    for (int t = 11; t <= 13; t++) begin
      a_drive(1, TW'(t), 0, 0, 0);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_count", 32'(a_count), 3);
    a_drive(1, 14, 1, 1, 0);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    a_drive(0, 0, 0, 0, 0);
    chk("rst_mid_count", 32'(a_count), 0);
    chk("rst_mid_valid", 32'(a_valid), 0);
    chk("rst_mid_overflow", 32'(a_overflow), 0);
    @(negedge clk);
    chk("rst_mid_ready", 32'(a_ready), 1);
    chk("rst_mid_not_empty", 32'(a_not_empty), 0);

    // instance B: five entries drained two lanes at a time
    for (int t = 20; t <= 24; t++) begin
      @(posedge clk);
      #1;
      b_drive(1, TW'(t), 2'b00, 0, 0);
      sb.push_back(TW'(t));
    end
    @(posedge clk);
    #1 b_drive(0, 0, 2'b00, 0, 0);
    chk("b_fill_count", 32'(b_count), 5);
    exp_bv3[0] = 2'b11; exp_bv3[1] = 2'b11; exp_bv3[2] = 2'b01;
    exp_cnt3[0] = 4'd3; exp_cnt3[1] = 4'd1; exp_cnt3[2] = 4'd0;
    for (int c = 0; c < 3; c++) begin
      b_drive(0, 0, 2'b11, 0, 0);
      @(negedge clk);
      chk($sformatf("b_drain%0d_bus_valid", c), 32'(b_bus_valid), 32'(exp_bv3[c]));
      for (int p = 0; p < 2; p++) begin
        lt = b_bus_tag[p*TW +: TW];
        if (b_bus_valid[p]) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_drain%0d_lane%0d: got tag %0d, expected no output", c, p, lt);
          end else begin
            exp_t = sb.pop_front();
            chk($sformatf("b_drain%0d_lane%0d_tag", c, p), 32'(lt), 32'(exp_t));
            chk($sformatf("b_drain%0d_lane%0d_data", c, p), b_bus_data[p*XLEN +: XLEN],
                vdat(exp_t));
            chk($sformatf("b_drain%0d_lane%0d_flags", c, p),
                {29'b0, b_bus_redir[p], b_bus_aexc[p], b_bus_uexc[p]}, 32'(exp_t[2:0]));
          end
        end else begin
          chk($sformatf("b_drain%0d_lane%0d_idle_tag", c, p), 32'(lt), 0);
        end
      end
      @(posedge clk);
      #1;
      chk($sformatf("b_drain%0d_count", c), 32'(b_count), 32'(exp_cnt3[c]));
    end
    chk("b_scoreboard_empty", 32'(sb.size()), 0);

    // squashed write during flush: dropped, no overflow, older entry kept
    b_drive(1, 10, 2'b00, 0, 0);
    @(posedge clk);
    #1 b_drive(1, 15, 2'b00, 1, 12);
    @(negedge clk);
    chk("b_flushwr_ready", 32'(b_ready), 1);
    @(posedge clk);
    #1;
    chk("b_flushwr_count", 32'(b_count), 1);
    chk("b_flushwr_overflow", 32'(b_overflow), 0);

    // non-contiguous permits: lane 1 always takes the second candidate
    b_drive(1, 16, 2'b00, 0, 0);
    @(posedge clk);
    #1 b_drive(0, 0, 2'b10, 0, 0);
    chk("b_nc_fill_count", 32'(b_count), 2);
    @(negedge clk);
    chk("b_nc1_bus_valid", 32'(b_bus_valid), 32'(2'b10));
    chk("b_nc1_lane1_tag", 32'(b_bus_tag[TW +: TW]), 16);
    @(posedge clk);
    #1 b_drive(0, 0, 2'b01, 0, 0);
    chk("b_nc1_count", 32'(b_count), 1);
    @(negedge clk);
    chk("b_nc2_bus_valid", 32'(b_bus_valid), 32'(2'b01));
    chk("b_nc2_lane0_tag", 32'(b_bus_tag[0 +: TW]), 10);
    @(posedge clk);
    #1 b_drive(0, 0, 2'b10, 0, 0);
    chk("b_nc2_count", 32'(b_count), 0);
    @(negedge clk);
    chk("b_nc3_bus_valid", 32'(b_bus_valid), 0);
    chk("b_nc3_lane1_tag", 32'(b_bus_tag[TW +: TW]), 0);
    chk("b_nc3_lane1_data", b_bus_data[XLEN +: XLEN], 0);
    @(posedge clk);
    #1 b_drive(0, 0, 2'b00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
